lfsr_rng: RTL and testbench
===========================

LFSR_RNG -- requirements
Module: lfsr_rng

Interface
REQ-001 Parameter WIDTH, default 8, register width; legal range 3..32.
REQ-002 Parameter SEED, default 8'h01 zero-extended to WIDTH, state loaded at reset.
REQ-003 Port order: reset_n, clk, q; positional instantiation relies on this order.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset; tie to 1 when unused.
REQ-006 q  output  WIDTH  current LFSR state, driven directly from the register.

Function
REQ-007 The block SHALL be a Fibonacci LFSR that shifts left every clk edge; there is no enable input.
- Next state: q <= {q[WIDTH-2:0], fb}.
- fb is the XOR of the tap bits selected for WIDTH.
REQ-008 For WIDTH=8, the taps SHALL be polynomial x^8+x^6+x^5+x^4+1, i.e. fb = q[7]^q[5]^q[4]^q[3].
REQ-009 For every legal WIDTH, the tap set SHALL be maximal-length, giving period 2^WIDTH-1 from any nonzero state.
REQ-010 q SHALL change exactly one cycle after each rising edge with reset_n high; there is no output latency beyond the register.
REQ-011 The all-zero state SHALL never be reached from a nonzero state.
REQ-012 Consumers derive ranges by modulo on q (e.g. q%26, q%71); the block itself SHALL apply no post-processing.
REQ-013 Several instances on different clocks SHALL be fully independent, with no shared state.

Reset
REQ-014 While reset_n=0, q SHALL equal SEED asynchronously, regardless of clk.
REQ-015 On reset_n deassertion, the first rising edge SHALL produce the successor of SEED.
REQ-016 Reset asserted mid-sequence SHALL immediately force SEED; no partial update is allowed.

Configuration
REQ-017 Macro LFSR_RNG_LOCKUP_GUARD_EN controls recovery from the all-zero state.
- Defined: if q is all-zero at a clk edge (SEED=0 or upset), the next state SHALL be 1; the guard uses a literal 1 because SEED may be 0.
- Not defined: all-zero SHALL persist, since the XOR feedback yields 0.

Structure
REQ-018 Package lfsr_rng_pkg SHALL hold the maximal-length tap-mask table for widths 3..32 (one mask constant per width), a function returning the mask for a width, and the default-seed constant.
REQ-019 Sub-module lfsr_rng_fb (combinational: state in, feedback bit out, parameterised by WIDTH and using the package mask) SHALL compute fb; lfsr_rng holds only the register, reset and the lockup guard.
REQ-020 Elaboration SHALL fail with an error if WIDTH is outside 3..32.

Verification
REQ-021 Reset, WIDTH=8, SEED=01: hold reset_n=0 -> q=01; release and clock 7 edges -> 02,04,08,11,23,47,8E.
REQ-022 Period: WIDTH=8, run 255 edges from 01 -> q returns to 01, with no zero and no repeat in between.
REQ-023 Async reset: assert reset_n=0 mid-cycle with no clk edge -> q=SEED immediately; clock edges while in reset -> q stays SEED.
REQ-024 Lockup, SEED=0:
- With LFSR_RNG_LOCKUP_GUARD_EN -> q=00 then 01, 02 on the next edges.
- Without the macro -> q=00 forever.
REQ-025 Width sweep: WIDTH=3, SEED=1 -> period 7; WIDTH=16 -> period 65535, verifying the table masks.
REQ-026 Independence: two instances on clocks of different frequency, both SEED=01 -> each follows REQ-021 on its own clock.

Source files
------------

// File: rtl/lfsr_rng_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_rng_pkg
// Shared constants for the lfsr_rng generator:
//   - legal width range and default width
//   - default seed (8'h01, zero-extended by the user of the constant)
//   - one maximal-length Fibonacci tap mask per width 3..32
//   - tap_mask(): returns the mask for a given width (0 for illegal widths)
// Mask bit n set means state bit q[n] feeds the XOR. The mask for width N
// is derived from a primitive polynomial x^N + ... + 1, where term x^k maps
// to bit k-1.
// -----------------------------------------------------------------------------
package lfsr_rng_pkg;

    localparam int MIN_WIDTH     = 3;
    localparam int MAX_WIDTH     = 32;
    localparam int DEFAULT_WIDTH = 8;

    localparam logic [7:0] DEFAULT_SEED = 8'h01;

    localparam logic [31:0] TAP_MASK_3  = 32'h0000_0006;  // x^3+x^2+1
    localparam logic [31:0] TAP_MASK_4  = 32'h0000_000C;  // x^4+x^3+1
    localparam logic [31:0] TAP_MASK_5  = 32'h0000_0014;  // x^5+x^3+1
    localparam logic [31:0] TAP_MASK_6  = 32'h0000_0030;  // x^6+x^5+1
    localparam logic [31:0] TAP_MASK_7  = 32'h0000_0060;  // x^7+x^6+1
    localparam logic [31:0] TAP_MASK_8  = 32'h0000_00B8;  // x^8+x^6+x^5+x^4+1
    localparam logic [31:0] TAP_MASK_9  = 32'h0000_0110;  // x^9+x^5+1
    localparam logic [31:0] TAP_MASK_10 = 32'h0000_0240;  // x^10+x^7+1
    localparam logic [31:0] TAP_MASK_11 = 32'h0000_0500;  // x^11+x^9+1
    localparam logic [31:0] TAP_MASK_12 = 32'h0000_0829;  // x^12+x^6+x^4+x+1
    localparam logic [31:0] TAP_MASK_13 = 32'h0000_100D;  // x^13+x^4+x^3+x+1
    localparam logic [31:0] TAP_MASK_14 = 32'h0000_2015;  // x^14+x^5+x^3+x+1
    localparam logic [31:0] TAP_MASK_15 = 32'h0000_6000;  // x^15+x^14+1
    localparam logic [31:0] TAP_MASK_16 = 32'h0000_D008;  // x^16+x^15+x^13+x^4+1
    localparam logic [31:0] TAP_MASK_17 = 32'h0001_2000;  // x^17+x^14+1
    localparam logic [31:0] TAP_MASK_18 = 32'h0002_0400;  // x^18+x^11+1
    localparam logic [31:0] TAP_MASK_19 = 32'h0004_0023;  // x^19+x^6+x^2+x+1
    localparam logic [31:0] TAP_MASK_20 = 32'h0009_0000;  // x^20+x^17+1
    localparam logic [31:0] TAP_MASK_21 = 32'h0014_0000;  // x^21+x^19+1
    localparam logic [31:0] TAP_MASK_22 = 32'h0030_0000;  // x^22+x^21+1
    localparam logic [31:0] TAP_MASK_23 = 32'h0042_0000;  // x^23+x^18+1
    localparam logic [31:0] TAP_MASK_24 = 32'h00E1_0000;  // x^24+x^23+x^22+x^17+1
    localparam logic [31:0] TAP_MASK_25 = 32'h0120_0000;  // x^25+x^22+1
    localparam logic [31:0] TAP_MASK_26 = 32'h0200_0023;  // x^26+x^6+x^2+x+1
    localparam logic [31:0] TAP_MASK_27 = 32'h0400_0013;  // x^27+x^5+x^2+x+1
    localparam logic [31:0] TAP_MASK_28 = 32'h0900_0000;  // x^28+x^25+1
    localparam logic [31:0] TAP_MASK_29 = 32'h1400_0000;  // x^29+x^27+1
    localparam logic [31:0] TAP_MASK_30 = 32'h2000_0029;  // x^30+x^6+x^4+x+1
    localparam logic [31:0] TAP_MASK_31 = 32'h4800_0000;  // x^31+x^28+1
    localparam logic [31:0] TAP_MASK_32 = 32'h8020_0003;  // x^32+x^22+x^2+x+1

    function automatic logic [31:0] tap_mask(input int width);
        logic [31:0] mask;
        case (width)
            3:       mask = TAP_MASK_3;
            4:       mask = TAP_MASK_4;
            5:       mask = TAP_MASK_5;
            6:       mask = TAP_MASK_6;
            7:       mask = TAP_MASK_7;
            8:       mask = TAP_MASK_8;
            9:       mask = TAP_MASK_9;
            10:      mask = TAP_MASK_10;
            11:      mask = TAP_MASK_11;
            12:      mask = TAP_MASK_12;
            13:      mask = TAP_MASK_13;
            14:      mask = TAP_MASK_14;
            15:      mask = TAP_MASK_15;
            16:      mask = TAP_MASK_16;
            17:      mask = TAP_MASK_17;
            18:      mask = TAP_MASK_18;
            19:      mask = TAP_MASK_19;
            20:      mask = TAP_MASK_20;
            21:      mask = TAP_MASK_21;
            22:      mask = TAP_MASK_22;
            23:      mask = TAP_MASK_23;
            24:      mask = TAP_MASK_24;
            25:      mask = TAP_MASK_25;
            26:      mask = TAP_MASK_26;
            27:      mask = TAP_MASK_27;
            28:      mask = TAP_MASK_28;
            29:      mask = TAP_MASK_29;
            30:      mask = TAP_MASK_30;
            31:      mask = TAP_MASK_31;
            32:      mask = TAP_MASK_32;
            default: mask = 32'h0000_0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// -----------------------------------------------------------------------------
// lfsr_rng_if
// Bundles the generator output for consumers that take it as an interface.
// The generator itself keeps plain ports (reset_n, clk, q) so positional
// instantiation stays valid; the producer side of this bundle is wired to q.
//   q : WIDTH-bit current LFSR state
// Modports:
//   master : drives q  (generator side)
//   slave  : reads q   (consumer side, e.g. q % 26)
// -----------------------------------------------------------------------------
interface lfsr_rng_if
    import lfsr_rng_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);

    logic [WIDTH-1:0] q;

    modport master (output q);
    modport slave  (input  q);

endinterface

// File: rtl/lfsr_rng_fb.sv
// -----------------------------------------------------------------------------
// lfsr_rng_fb
// Combinational feedback bit for a Fibonacci LFSR of width WIDTH, using the
// maximal-length tap mask from lfsr_rng_pkg.
// Ports:
//   state_i : WIDTH-bit current state
//   fb_o    : XOR of the tapped state bits
// -----------------------------------------------------------------------------
module lfsr_rng_fb
    import lfsr_rng_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] state_i,
    output logic             fb_o
);

    localparam logic [WIDTH-1:0] MASK = WIDTH'(tap_mask(WIDTH));

    assign fb_o = ^(state_i & MASK);

endmodule

// File: rtl/lfsr_rng.sv
// -----------------------------------------------------------------------------
// lfsr_rng
// Free-running Fibonacci LFSR pseudo-random generator. Shifts left on every
// rising clk edge: q <= {q[WIDTH-2:0], fb}. No enable, no post-processing;
// consumers reduce the range themselves.
// Parameters:
//   WIDTH : register width, 3..32 (anything else stops elaboration)
//   SEED  : value loaded while reset_n is low (default 8'h01 zero-extended)
// Ports (order is relied upon by positional instantiations):
//   reset_n : asynchronous active-low reset, forces q to SEED immediately
//   clk     : rising-edge clock
//   q       : current state, straight from the register
// Configuration macro:
//   LFSR_RNG_LOCKUP_GUARD_EN : when defined, an all-zero state is replaced by
//                              1 on the next edge; when undefined, all-zero
//                              persists (XOR feedback of zeros is zero).
// -----------------------------------------------------------------------------
module lfsr_rng
    import lfsr_rng_pkg::*;
#(
    parameter int               WIDTH = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic             reset_n,
    input  logic             clk,
    output logic [WIDTH-1:0] q
);

    generate
        if (WIDTH < MIN_WIDTH || WIDTH > MAX_WIDTH) begin : g_bad_width
            $error("lfsr_rng: WIDTH=%0d outside legal range %0d..%0d",
                   WIDTH, MIN_WIDTH, MAX_WIDTH);
        end
    endgenerate

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             fb;

    lfsr_rng_fb #(
        .WIDTH (WIDTH)
    ) u_fb (
        .state_i (q_q),
        .fb_o    (fb)
    );

    always_comb begin
        q_d = {q_q[WIDTH-2:0], fb};
`ifdef LFSR_RNG_LOCKUP_GUARD_EN
        // Literal 1 rather than SEED: SEED itself may be zero.
        if (q_q == '0) begin
            q_d = WIDTH'(1);
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rng
// Directed bench for lfsr_rng: reset value, WIDTH=8 sequence, async reset,
// 255-step period, lockup behaviour for SEED=0 (both macro settings),
// WIDTH=3 / WIDTH=16 periods and two instances on unrelated clocks.
// -----------------------------------------------------------------------------
module tb_lfsr_rng;

    logic clk   = 1'b0;
    logic clk_b = 1'b0;
    logic rst_n;
    logic rst_b;

    always #5 clk   = ~clk;
    always #7 clk_b = ~clk_b;

    lfsr_rng_if #(.WIDTH(8)) a_if ();
    lfsr_rng_if #(.WIDTH(8)) b_if ();

    logic [7:0]  z_q;
    logic [2:0]  w3_q;
    logic [15:0] w16_q;

    lfsr_rng #(.WIDTH(8), .SEED(8'h01)) u_a (
        .reset_n (rst_n), .clk (clk), .q (a_if.q)
    );
    lfsr_rng #(.WIDTH(8), .SEED(8'h01)) u_b (
        .reset_n (rst_b), .clk (clk_b), .q (b_if.q)
    );
    lfsr_rng #(.WIDTH(8), .SEED(8'h00)) u_zero (
        .reset_n (rst_n), .clk (clk), .q (z_q)
    );
    lfsr_rng #(.WIDTH(3), .SEED(3'd1)) u_w3 (
        .reset_n (rst_n), .clk (clk), .q (w3_q)
    );
    lfsr_rng #(.WIDTH(16), .SEED(16'h0001)) u_w16 (
        .reset_n (rst_n), .clk (clk), .q (w16_q)
    );

    int errors = 0;
    int checks = 0;
    int a_edges = 0;

    always @(posedge clk) a_edges <= a_edges + 1;

    // Hand-computed successors of 01 for x^8+x^6+x^5+x^4+1.
    logic [7:0] exp8 [7] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E};
    // Successors of 1 for x^3+x^2+1.
    logic [2:0] exp3 [7] = '{3'd2, 3'd5, 3'd3, 3'd7, 3'd6, 3'd4, 3'd1};
`ifdef LFSR_RNG_LOCKUP_GUARD_EN
    logic [7:0] expz [3] = '{8'h01, 8'h02, 8'h04};
    logic [7:0] z_after_255 = 8'h80;  // 01 after 254 steps = predecessor of 01
`else
    logic [7:0] expz [3] = '{8'h00, 8'h00, 8'h00};
    logic [7:0] z_after_255 = 8'h00;
`endif

    function automatic logic [7:0] nxt8(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic seen [256];
    int   dups;
    int   zeros;
    int   p3;
    int   p16;
    int   z16;
    int   a_start;
    logic [7:0] model;

    initial begin
        rst_n = 1'b0;
        rst_b = 1'b0;

        // Reset held across clock edges: every instance sits at its SEED.
        repeat (3) step();
        check("reset_w8",   32'(a_if.q), 32'h01);
        check("reset_zero", 32'(z_q),    32'h00);
        check("reset_w3",   32'(w3_q),   32'h1);
        check("reset_w16",  32'(w16_q),  32'h0001);
        check("reset_b",    32'(b_if.q), 32'h01);

        // First seven edges after release.
        rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            check("seq_w8", 32'(a_if.q), 32'(exp8[i]));
            check("seq_w3", 32'(w3_q),   32'(exp3[i]));
            if (i < 3) check("lockup_zero", 32'(z_q), 32'(expz[i]));
        end

        // Asynchronous reset mid-cycle, no clock edge in between.
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_w8", 32'(a_if.q), 32'h01);
        check("async_reset_w3", 32'(w3_q),   32'h1);
        repeat (2) step();
        check("reset_hold_w8", 32'(a_if.q), 32'h01);
        rst_n = 1'b1;
        step();
        check("first_after_release", 32'(a_if.q), 32'h02);

        // Full WIDTH=8 period: no zero and no repeat before returning to 01.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1] = 1'b1;
        dups  = 0;
        zeros = 0;
        for (int i = 1; i <= 255; i++) begin
            step();
            if (i < 255) begin
                if (a_if.q == 8'h00) zeros++;
                if (seen[a_if.q]) dups++;
                seen[a_if.q] = 1'b1;
            end
        end
        check("period_w8_return", 32'(a_if.q), 32'h01);
        check("period_w8_dups",   32'(dups),   32'd0);
        check("period_w8_zeros",  32'(zeros),  32'd0);
        check("zero_after_255",   32'(z_q),    32'(z_after_255));

        // Width sweep: measure edges until each returns to its seed.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        p3  = 0;
        p16 = 0;
        z16 = 0;
        for (int n = 1; n <= 70000 && (p3 == 0 || p16 == 0); n++) begin
            step();
            if (p3 == 0 && w3_q == 3'd1) p3 = n;
            if (p16 == 0 && w16_q == 16'h0001) p16 = n;
            if (w16_q == 16'h0000) z16++;
        end
        check("period_w3",   32'(p3),  32'd7);
        check("period_w16",  32'(p16), 32'd65535);
        check("zeros_w16",   32'(z16), 32'd0);

        // Independence: A free-runs on clk while B is held, then B is released.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        a_start = a_edges;
        repeat (3) step();
        check("b_held", 32'(b_if.q), 32'h01);
        @(negedge clk_b);
        rst_b = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk_b);
            @(negedge clk_b);
            check("seq_b", 32'(b_if.q), 32'(exp8[i]));
        end
        model = 8'h01;
        for (int i = 0; i < a_edges - a_start; i++) model = nxt8(model);
        check("a_own_clock", 32'(a_if.q), 32'(model));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
